// File: rtl/i8253_counter.sv
// i8253_counter: count register, count element and OUT logic for one i8253 channel.
// The FSM tracks two things: whether a new CR is waiting to load, and whether the channel counts.
module i8253_counter (
  input  logic        clk21m,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        gate,
  input  logic        wr_cw,
  input  logic        wr_lsb,
  input  logic        wr_msb,
  input  logic        wr_trigger,
  input  logic [7:0]  wr_d,
  input  logic        mode0,
  input  logic        mode1,
  input  logic        mode2,
  input  logic        mode3,
  input  logic        mode4,
  input  logic        mode5,
  input  logic        bcd,
  output logic [15:0] counter,
  output logic        out
);

  // state[1] = counting (armed), state[0] = load pending
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PEND     = 2'b01,
    ST_RUN      = 2'b10,
    ST_RUN_PEND = 2'b11
  } state_t;

  state_t      state, state_next;
  logic [15:0] cr, ce;
  logic        out_r, gate_prev, strobe;
  logic        armed, pending, tick, gate_edge;
  logic        do_load, do_gate_reload, do_count, do_term;
  logic        arm_n, pend_n;
  logic [15:0] ce_dec1, ce_dec2, cr_inc, load_val, term3_val;

  function automatic logic [15:0] dec1(input logic [15:0] v, input logic is_bcd);
    logic [15:0] r;
    logic        borrow;
    r = v - 16'd1;
    if (is_bcd) begin
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (borrow) begin
          if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
          else begin
            r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
            borrow      = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] inc1(input logic [15:0] v, input logic is_bcd);
    logic [15:0] r;
    logic        carry;
    r = v + 16'd1;
    if (is_bcd) begin
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
          else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign armed     = state[1];
  assign pending   = state[0];
  assign tick      = clk_en & ~wr_cw;
  assign gate_edge = gate & ~gate_prev;
  assign ce_dec1   = dec1(ce, bcd);
  assign ce_dec2   = dec1(ce_dec1, bcd);
  assign cr_inc    = inc1(cr, bcd);
  // Odd square-wave counts start their high half one step longer (N+1), low half shorter (N-1).
  assign load_val  = (mode3 & cr[0]) ? cr_inc : cr;
  assign term3_val = ~cr[0] ? cr : (out_r ? {cr[15:1], 1'b0} : cr_inc);

  always_ff @(posedge clk21m) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    arm_n  = armed;
    pend_n = pending;
    if (do_load) begin
      arm_n  = 1'b1;
      pend_n = 1'b0;
    end
    if (do_gate_reload | do_term) pend_n = 1'b0;
    if (mode0 & (wr_lsb | wr_msb) & ~wr_trigger) arm_n = 1'b0;
    if (wr_trigger) pend_n = 1'b1;
    if (wr_cw) begin
      arm_n  = 1'b0;
      pend_n = 1'b0;
    end
    state_next = state_t'({arm_n, pend_n});
  end

  // Per-tick actions decoded from the FSM state; a trigger on this tick is not yet visible.
  always_comb begin
    do_load        = 1'b0;
    do_gate_reload = 1'b0;
    do_count       = 1'b0;
    do_term        = 1'b0;
    if (tick) begin
      if (mode1 | mode5) begin
        do_load = gate_edge & (pending | armed);
      end else if (mode2 | mode3) begin
        do_load        = pending & ~armed;
        do_gate_reload = armed & gate_edge;
      end else begin
        do_load = pending;
      end
      do_count = armed & ~do_load & ~do_gate_reload & (mode1 | mode5 | gate);
      do_term  = do_count & ((mode2 & (ce == 16'h0001)) | (mode3 & (ce == 16'h0002)));
    end
  end

  always_ff @(posedge clk21m) begin
    if (reset) begin
      cr        <= 16'h0000;
      ce        <= 16'h0000;
      out_r     <= 1'b1;
      gate_prev <= 1'b0;
      strobe    <= 1'b0;
    end else begin
      if (clk_en) gate_prev <= gate;
      if (wr_cw) begin
        out_r  <= ~mode0;
        strobe <= 1'b0;
      end else begin
        if (wr_lsb) cr[7:0]  <= wr_d;
        if (wr_msb) cr[15:8] <= wr_d;
        if ((mode2 | mode3) & ~gate) out_r <= 1'b1;
        if (tick & (mode4 | mode5)) out_r <= 1'b1;
        if (do_load | do_gate_reload) begin
          ce <= load_val;
          if (mode1) out_r <= 1'b0;
          if (mode2 | mode3) out_r <= 1'b1;
          if (mode4 | mode5) strobe <= 1'b1;
        end else if (do_count) begin
          if (mode3) begin
            if (ce == 16'h0002) begin
              out_r <= ~out_r;
              ce    <= term3_val;
            end else begin
              ce <= ce_dec2;
            end
          end else if (mode2) begin
            if (ce == 16'h0001) begin
              ce    <= cr;
              out_r <= 1'b1;
            end else begin
              ce    <= ce_dec1;
              out_r <= (ce_dec1 != 16'h0001);
            end
          end else begin
            ce <= ce_dec1;
            if (ce_dec1 == 16'h0000) begin
              if (mode0 | mode1) out_r <= 1'b1;
              if ((mode4 | mode5) & strobe) begin
                out_r  <= 1'b0;
                strobe <= 1'b0;
              end
            end
          end
        end
        if (wr_trigger) begin
          if (mode0) out_r  <= 1'b0;
          if (mode4) strobe <= 1'b1;
        end
      end
    end
  end

  assign counter = ce;
  assign out     = out_r;

endmodule
